// File: rtl/burrito_sequencer.sv
// rtl/burrito_sequencer.sv - instruction memory and fetch/issue sequencer for the Burrito datapath
module burrito_sequencer #(
  parameter int             IW        = 20,
  parameter int             DEPTH     = 32,
  parameter int             AW        = 5,
  parameter logic [IW-1:0]  HALT_WORD = 20'h78000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [IW-1:0] instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [IW-1:0] mem [DEPTH];
  logic [AW:0]   len;
  logic [AW:0]   len_in;
  logic          halt_seen;
  logic          handshake;
  logic          last;
  logic [IW-1:0] rd_word;

  assign len_in    = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign handshake = (state == ISSUE) && instr_valid && instr_ready;
  assign last      = ({1'b0, pc} == (len - (AW+1)'(1)));
  assign rd_word   = mem[pc];
  assign busy      = (state == FETCH) || (state == ISSUE);
  assign done      = (state == DONE);

  // Host writes are only honoured while no program is running.
  always_ff @(posedge clk) begin
    if (load_we && (state == IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len_in != '0) ? FETCH : DONE;
        end
      end
      FETCH: next_state = ISSUE;
      ISSUE: begin
        if (halt_seen) begin
          next_state = DONE;
        end else if (handshake) begin
          next_state = last ? DONE : FETCH;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The memory read lands straight in the output register, so a halt word is
  // squashed before it can ever appear on instr_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= '0;
      len         <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halt_seen   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len <= len_in;
            if (len_in != '0) begin
              pc <= '0;
            end
          end
        end
        FETCH: begin
          halt_seen   <= (rd_word == HALT_WORD);
          instr_valid <= (rd_word != HALT_WORD);
          instr_out   <= (rd_word == HALT_WORD) ? '0 : rd_word;
        end
        ISSUE: begin
          if (handshake) begin
            instr_valid <= 1'b0;
            instr_out   <= '0;
            if (!last) begin
              pc <= pc + AW'(1);
            end
          end
        end
        default: begin
          instr_valid <= 1'b0;
          instr_out   <= '0;
          halt_seen   <= 1'b0;
        end
      endcase
    end
  end

endmodule
